// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module : des_pkg
// Brief  : Shared DES constants, permutation/S-box tables and FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
package des_pkg;

    localparam int c_block_w = 64;
    localparam int c_half_w  = 32;
    localparam int c_key_w   = 48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_FINISH = 2'd2
    } des_state_t;

    // Table entries use DES bit numbering: bit 1 is the MSB of the vector.
    localparam int c_ip [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int c_fp [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int c_e [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int c_p [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Indexed by {row, col} = {b1, b6, b2..b5} of the 6-bit input.
    localparam int c_sbox [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] des_ip(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - c_ip[6'(i)])];
        return o;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - c_fp[6'(i)])];
        return o;
    endfunction

    function automatic logic [47:0] des_e(input logic [31:0] r);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = r[5'(32 - c_e[6'(i)])];
        return o;
    endfunction

    function automatic logic [31:0] des_p(input logic [31:0] s);
        logic [31:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[5'(31 - i)] = s[5'(32 - c_p[5'(i)])];
        return o;
    endfunction

    function automatic logic [3:0] des_sbox(input logic [2:0] n, input logic [5:0] b);
        return 4'(c_sbox[n][{b[5], b[0], b[4:1]}]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_f.sv
`default_nettype none
// ============================================================================
// Module : des_f
// Brief  : Combinational DES round function F = P(S(E(R) ^ K)).
// Rev    : 1.0  initial release
// ============================================================================
module des_f
    import des_pkg::*;
(
    input  logic [32:1] r,
    input  logic [48:1] k,
    output logic [32:1] f
);

    logic [c_key_w-1:0]  w_x;
    logic [c_half_w-1:0] w_s;

    assign w_x = des_e(r) ^ k;

    generate
        for (genvar g = 0; g < 8; g++) begin : g_sbox
            assign w_s[31-4*g -: 4] = des_sbox(3'(g), w_x[47-6*g -: 6]);
        end
    endgenerate

    assign f = des_p(w_s);

endmodule
`default_nettype wire

// File: rtl/des_round_engine.sv
`default_nettype none
// ============================================================================
// Module : des_round_engine
// Brief  : Iterative DES encrypt/decrypt, one Feistel round per clock.
// Rev    : 1.0  initial release
// ============================================================================
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [64:1] data_in,
    input  logic [48:1] key1,
    input  logic [48:1] key2,
    input  logic [48:1] key3,
    input  logic [48:1] key4,
    input  logic [48:1] key5,
    input  logic [48:1] key6,
    input  logic [48:1] key7,
    input  logic [48:1] key8,
    input  logic [48:1] key9,
    input  logic [48:1] key10,
    input  logic [48:1] key11,
    input  logic [48:1] key12,
    input  logic [48:1] key13,
    input  logic [48:1] key14,
    input  logic [48:1] key15,
    input  logic [48:1] key16,
    output logic [64:1] data_out,
    output logic        busy,
    output logic        done
);

    des_state_t           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [c_half_w-1:0]  r_l;
    logic [c_half_w-1:0]  r_r;
    logic                 r_decrypt;
    logic                 r_busy;
    logic                 r_done;
    logic [c_block_w-1:0] r_dout;

    logic [c_block_w-1:0] w_ip;
    logic [c_block_w-1:0] w_fp;
    logic [c_half_w-1:0]  w_f;
    logic [c_key_w-1:0]   w_keys [NUM_ROUNDS];
    logic [c_key_w-1:0]   w_key;
    logic [CNT_W-1:0]     w_kidx;

    assign w_keys = '{key1, key2, key3, key4, key5, key6, key7, key8,
                      key9, key10, key11, key12, key13, key14, key15, key16};

    // Decryption walks the same schedule backwards.
    assign w_kidx = r_decrypt ? (CNT_W'(NUM_ROUNDS - 1) - r_cnt) : r_cnt;
    assign w_key  = w_keys[w_kidx];

    assign w_ip = des_ip(data_in);
    assign w_fp = des_fp({r_r, r_l});

    des_f u_f (
        .r (r_r),
        .k (w_key),
        .f (w_f)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_l       <= '0;
            r_r       <= '0;
            r_decrypt <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_l       <= w_ip[63:32];
                        r_r       <= w_ip[31:0];
                        r_decrypt <= decrypt;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_l   <= r_r;
                    r_r   <= r_l ^ w_f;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(NUM_ROUNDS - 1)) begin
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_dout  <= w_fp;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_out = r_dout;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_des_round_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_des_round_engine
// Brief  : Self-checking bench for des_round_engine against a DES model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [63:0] data_in = '0;
    logic [63:0] data_out;
    logic        busy;
    logic        done;
    logic [47:0] sk [16];

    int tests = 0;
    int failed = 0;

    localparam int t_ip [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int t_fp [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int t_e [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int t_p [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int t_pc1 [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int t_pc2 [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int t_sh [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int t_s [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    always #5 clk = ~clk;

    des_round_engine dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .decrypt  (decrypt),
        .data_in  (data_in),
        .key1     (sk[0]),
        .key2     (sk[1]),
        .key3     (sk[2]),
        .key4     (sk[3]),
        .key5     (sk[4]),
        .key6     (sk[5]),
        .key7     (sk[6]),
        .key8     (sk[7]),
        .key9     (sk[8]),
        .key10    (sk[9]),
        .key11    (sk[10]),
        .key12    (sk[11]),
        .key13    (sk[12]),
        .key14    (sk[13]),
        .key15    (sk[14]),
        .key16    (sk[15]),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Standard key schedule: PC-1, per-round left rotations, PC-2.
    task automatic make_keys(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - t_pc1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < t_sh[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - t_pc2[i])];
            sk[r] = k;
        end
    endtask

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, p;
        int six, row, col;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = r[5'(32 - t_e[i])];
        e = e ^ k;
        for (int b = 0; b < 8; b++) begin
            six = int'(e[6'(47 - 6 * b) -: 6]);
            row = (six / 32) * 2 + (six % 2);
            col = (six / 2) % 16;
            s[5'(31 - 4 * b) -: 4] = 4'(t_s[b][row * 16 + col]);
        end
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - t_p[i])];
        return p;
    endfunction

    function automatic logic [63:0] des_model(input logic [63:0] blk, input bit dec);
        logic [63:0] x, pre, o;
        logic [31:0] l, r, t;
        for (int i = 0; i < 64; i++) x[6'(63 - i)] = blk[6'(64 - t_ip[i])];
        l = x[63:32];
        r = x[31:0];
        for (int n = 0; n < 16; n++) begin
            t = r;
            r = l ^ model_f(r, dec ? sk[15 - n] : sk[n]);
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) o[6'(63 - i)] = pre[6'(64 - t_fp[i])];
        return o;
    endfunction

    // Launch one block, optionally poke START mid-flight, and check the result.
    task automatic run_block(input string tag, input logic [63:0] blk, input bit dec,
                             input logic [63:0] exp, input int inject_at);
        int n;
        bit busy_ok;
        logic [63:0] prev;
        @(negedge clk);
        data_in = blk;
        decrypt = dec;
        start   = 1'b1;
        prev    = data_out;
        @(negedge clk);
        start   = 1'b0;
        data_in = {$urandom, $urandom};
        decrypt = ~dec;
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1 || data_out !== prev) busy_ok = 1'b0;
            if (n == inject_at) begin
                start   = 1'b1;
                data_in = '1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd17);
        check({tag, "_busy_hold"}, 64'(busy_ok), 64'd1);
        check({tag, "_data"}, data_out, exp);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    endtask

    logic [63:0] v, blk, exp, prev;
    logic [63:0] drv[$];
    int pulses;
    bit b2b_ok;

    initial begin
        make_keys(64'h133457799BBCDFF1);
        repeat (3) @(negedge clk);
        check("rst_data", data_out, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        run_block("gold_enc", 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, -1);
        run_block("gold_dec", 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF, -1);

        make_keys(64'h0E329232EA6D0D73);
        run_block("vec2_enc", 64'h8787878787878787, 1'b0, 64'h0000000000000000, -1);

        make_keys(64'h133457799BBCDFF1);
        run_block("busy_prot", 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, 5);
        pulses = 0;
        b2b_ok = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (busy !== 1'b0) b2b_ok = 1'b0;
        end
        check("busy_prot_no_rerun", 64'(pulses), 64'd0);
        check("busy_prot_idle", 64'(b2b_ok), 64'd1);

        for (int t = 0; t < 4; t++) begin
            make_keys({$urandom, $urandom});
            blk = {$urandom, $urandom};
            exp = des_model(blk, 1'b0);
            run_block("rnd_enc", blk, 1'b0, exp, -1);
            run_block("rnd_dec", exp, 1'b1, blk, -1);
        end

        // START held high: a new block is taken every 18 clocks.
        make_keys({$urandom, $urandom});
        @(negedge clk);
        v = {$urandom, $urandom};
        drv.push_back(v);
        data_in = v;
        decrypt = 1'b0;
        start   = 1'b1;
        prev    = data_out;
        pulses  = 0;
        b2b_ok  = 1'b1;
        for (int n = 0; n < 54; n++) begin
            @(negedge clk);
            if (done === 1'b1 && n >= 17) begin
                pulses++;
                check("b2b_data", data_out, des_model(drv[n - 17], 1'b0));
            end
            if ((done === 1'b1) != ((n % 18) == 17)) b2b_ok = 1'b0;
            if (done !== 1'b1 && data_out !== prev) b2b_ok = 1'b0;
            prev = data_out;
            v = {$urandom, $urandom};
            drv.push_back(v);
            data_in = v;
        end
        start = 1'b0;
        check("b2b_pulses", 64'(pulses), 64'd3);
        check("b2b_timing", 64'(b2b_ok), 64'd1);

        // Abort in the middle of round 8 with an asynchronous reset.
        make_keys(64'h133457799BBCDFF1);
        @(negedge clk);
        data_in = 64'h0123456789ABCDEF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_data", data_out, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        run_block("post_abort", 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405, -1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
- Iterative DES datapath, directly downstream of the key-schedule stage.
- Consumes the 16 precomputed 48-bit round subkeys KEY1..KEY16 and encrypts or decrypts one 64-bit block, one Feistel round per clock.
- Holds the result and pulses DONE.
- Sits between the bus/host interface (block source) and the result register/readback logic.

Parameters:
- NUM_ROUNDS, 16, number of Feistel rounds. Fixed for DES; exists only to size the round counter.
- CNT_W, 4, round counter width.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  request to process DATA_IN; sampled only in IDLE
- DECRYPT  in  1  0 = encrypt, 1 = decrypt; captured with START
- DATA_IN  in  64 [64:1]  input block; bit 64 = DES bit 1
- KEY1..KEY16  in  48 each [48:1]  round subkeys; bit 48 = subkey bit 1; must be stable from START until DONE
- DATA_OUT  out  64 [64:1]  result block, registered
- BUSY  out  1  high while a block is in flight
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, RESET=1):
  - state=IDLE, round counter=0, L=R=0.
  - DATA_OUT=0, BUSY=0, DONE=0, decrypt flag=0.
- States: IDLE, ROUND, FINISH.
- IDLE:
  - On an edge with START=1: L<=IP(DATA_IN)[64:33], R<=IP(DATA_IN)[32:1]; capture DECRYPT; cnt<=0; BUSY<=1; go to ROUND.
  - START=0: stay in IDLE.
- ROUND, one round per edge:
  - L<=R; R<=L XOR f(R, K); cnt<=cnt+1.
  - K = KEY(cnt+1) when encrypting; KEY(16-cnt) when decrypting.
  - On the edge where cnt==15, go to FINISH. The counter wraps to 0; this is harmless.
- FINISH, one edge:
  - DATA_OUT<=FP({R,L}) (final half swap); DONE<=1; BUSY<=0; state<=IDLE.
- DONE is high exactly one cycle, the cycle after the FINISH edge. It is cleared on the next edge.
- Timing:
  - START sampled at edge 0; rounds at edges 1..16; DATA_OUT/DONE update at edge 17.
  - Latency 17 clocks. A new START is accepted at edge 18 or later, giving a minimum period of 18 clocks.
- START during ROUND/FINISH is ignored. It is not queued and does not disturb the block in flight.
- START during the DONE cycle (state is IDLE) is accepted normally.
- DATA_OUT holds its value until the next FINISH or reset. It is not cleared at START.
- DECRYPT and DATA_IN are used only on the START edge; changes afterwards have no effect.
- f(R,K) = P(S(E(R) XOR K)):
  - E: 32->48 expansion.
  - S: eight 6->4 S-boxes, row = outer bits, column = inner 4 bits.
  - P: 32-bit permutation.
  - All per FIPS 46-3, combinational within one cycle.
- Reset asserted mid-operation aborts the block immediately. No DONE is produced; all outputs return to reset values.

Decomposition:
- Shared package des_pkg:
  - IP, FP, E, P permutation tables.
  - S1..S8 tables.
  - Block/half/subkey width constants (64/32/48).
  - State encoding.
- Sub-module des_f: purely combinational R[32:1], K[48:1] -> F[32:1] (expansion, key XOR, S-boxes, P).
- des_round_engine owns the FSM, the counter, the L/R registers, IP/FP and the subkey mux.

Test Plan:
- Encrypt: subkeys from the golden schedule for key 133457799BBCDFF1, DATA_IN=0123456789ABCDEF, START=1 one cycle, DECRYPT=0 -> DONE exactly 17 clocks later, DATA_OUT=85E813540F0AB405, BUSY high for edges 1..17.
- Decrypt: same subkeys, DATA_IN=85E813540F0AB405, DECRYPT=1 -> DATA_OUT=0123456789ABCDEF after 17 clocks.
- Second vector: key 0E329232EA6D0D73, DATA_IN=8787878787878787, encrypt -> DATA_OUT=0000000000000000.
- Busy protection: pulse START with DATA_IN=FFFFFFFFFFFFFFFF at clock 5 of an operation -> first result unchanged (85E813540F0AB405), only one DONE pulse, no second run.
- Back-to-back: START held high continuously -> DONE pulses every 18 clocks; DATA_OUT updates only on DONE edges.
- Reset mid-flight: assert RESET asynchronously (between edges) at round 8 -> DATA_OUT=0, BUSY=0, DONE=0 immediately, no DONE afterwards. A following START completes correctly in 17 clocks.
